id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipeline, directly upstream of the EX-stage ALU.
//  - Registers decoded ID-stage fields.
//  - Translates opcode/funct into the ALU's 3-bit Ctl code.
//  - Forwards EX/MEM and MEM/WB results onto the ALU operands.
//  - Detects load-use hazards, inserting a bubble and telling IF/ID to hold.
// PARAMETERS
//  XLEN      32  datapath width (DataA/DataB/forward/store data)
//  REGADDR    5  register-number width
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     asynchronous, active-high reset
//  Stall         in   1     global pipeline hold (memory wait); stage register keeps its value
//  Flush         in   1     branch taken; stage register loads a bubble
//  IdValid       in   1     ID holds a real instruction
//  IdOpcode      in   6     instr[31:26]
//  IdFunct       in   6     instr[5:0]
//  IdShamt       in   5     instr[10:6]
//  IdRs/IdRt/IdRd in  5     register numbers
//  IdRsData      in   XLEN  register-file read A
//  IdRtData      in   XLEN  register-file read B
//  IdImm         in   16    instr[15:0]
//  MemRegWrite   in   1     EX/MEM writes a register
//  MemRd         in   5     EX/MEM destination
//  MemData       in   XLEN  EX/MEM ALU result
//  WbRegWrite    in   1     MEM/WB writes a register
//  WbRd          in   5     MEM/WB destination
//  WbData        in   XLEN  MEM/WB write-back value
//  HazardStall   out  1     load-use detected; IF/ID and PC must hold (combinational)
//  ExValid       out  1     EX holds a real instruction
//  Ctl           out  3     ALU op: AND 000, OR 001, ADD 010, SUB 110, SLT 011, SRL 111
//  Shamt         out  5     ALU shift amount
//  DataA, DataB  out  XLEN  forwarded ALU operands
//  ExStoreData   out  XLEN  forwarded rt value for sw
//  ExRegWrite    out  1     EX instruction writes a register
//  ExMemRead     out  1     EX instruction is lw
//  ExMemWrite    out  1     EX instruction is sw
//  ExBranch      out  1     EX instruction is beq
//  ExWriteReg    out  5     destination register: rd for R-type, rt for I-type
// BEHAVIOUR
//  - Reset (async):
//    - All registered state is 0; ExValid=0, Ctl=000.
//    - Forwarding sources are forced to "none" while ExValid=0.
//    - HazardStall=0 while rst is asserted.
//  - Register update at the clk edge, in priority order:
//    1. Flush: bubble.
//    2. Stall: hold.
//    3. HazardStall: bubble.
//    4. Otherwise: load ID fields.
//  - Bubble definition: ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExBranch all 0; other fields don't-care.
//  - Latency: ID fields appear on the outputs 1 cycle after load.
//  - Decode (registered):
//    - R-type (op 000000), ExRegWrite=1, ExWriteReg=rd:
//      - funct 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR.
//      - funct 101010 -> SLT; 000010 -> SRL.
//    - I-type:
//      - addi 001000 -> ADD, RegWrite, imm.
//      - lw 100011 -> ADD, MemRead, RegWrite, imm.
//      - sw 101011 -> ADD, MemWrite, imm.
//      - beq 000100 -> SUB, Branch, rt operand.
//    - Unsupported op/funct -> Ctl=ADD, all control 0, ExValid kept (acts as nop).
//    - ExWriteReg=0 forces ExRegWrite=0.
//  - Immediate: sign-extended to XLEN. DataB=imm for addi/lw/sw, otherwise forwarded rt.
//  - Forwarding (combinational on registered rs/rt, per operand):
//    - EX/MEM if MemRegWrite && MemRd!=0 && MemRd==reg.
//    - Else MEM/WB if WbRegWrite && WbRd!=0 && WbRd==reg.
//    - Else registered data.
//    - EX/MEM has priority over MEM/WB.
//  - HazardStall = ExValid & ExMemRead & ExWriteReg!=0 & IdValid & (IdRs==ExWriteReg | IdRt==ExWriteReg).
//    - Asserted for exactly 1 cycle per load-use; the next cycle the load is in MEM and forwarding covers it.
//  - Simultaneous Flush+HazardStall: Flush wins and a bubble is inserted.
//  - Stall+HazardStall: hold; HazardStall stays high until the load advances.
//  - Shamt passes through registered; only meaningful when Ctl=111.
//  - Reset mid-operation: the instruction in the register is discarded.
// STRUCTURE
//  - Shared package pipe_pkg holds:
//    - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SRL);
//    - ALU Ctl encodings (CTL_AND..CTL_SRL).
//  - One sub-module alu_ctl_decode: opcode/funct -> Ctl, RegWrite, MemRead, MemWrite, Branch, UseImm, RegDst.
//  - The forwarding muxes and hazard compare stay inline.
// TESTING
//  - add rd=3: rs=1, rt=2 with IdRsData=5, IdRtData=7 -> next cycle Ctl=010, DataA=5, DataB=7, ExWriteReg=3, ExRegWrite=1.
//  - EX/MEM forward: MemRegWrite=1, MemRd=1, MemData=0xAA; registered rs=1 -> DataA=0xAA.
//    Add WbRd=1, WbData=0xBB -> DataA stays 0xAA.
//  - $0 guard: MemRd=0, MemRegWrite=1, rs=0 -> DataA = registered rs data, never MemData.
//  - Load-use: lw $4 in EX, ID add rs=4 -> HazardStall=1 one cycle; next cycle ExValid=0, then the add loads.
//  - addi rt=5, IdImm=0xFFFC -> DataB=0xFFFFFFFC, Ctl=010, ExWriteReg=5.
//    srl shamt=3 -> Ctl=111, Shamt=3.
//  - Flush with Stall high -> bubble (ExValid=0).
//    Stall alone holds all outputs 3 cycles.
//    rst asserted mid-stream -> ExValid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline:
//   - opcode / funct field values recognised by the decoder
//   - 3-bit ALU control encodings consumed by the EX-stage ALU
//   - dec_t : decoded control bundle produced by alu_ctl_decode
//   - fwd_e : operand forwarding source selector
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SLT = 3'b011;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SRL = 3'b111;

  typedef struct packed {
    logic [2:0] ctl;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       useImm;
    logic       regDst;   // 1: destination is rd (R-type), 0: rt
  } dec_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   master : the surrounding pipeline (drives ID fields, stall/flush,
//            EX/MEM and MEM/WB forwarding info; receives EX outputs)
//   slave  : the id_ex_stage register itself
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               Stall;
  logic               Flush;
  logic               IdValid;
  logic [5:0]         IdOpcode;
  logic [5:0]         IdFunct;
  logic [4:0]         IdShamt;
  logic [REGADDR-1:0] IdRs;
  logic [REGADDR-1:0] IdRt;
  logic [REGADDR-1:0] IdRd;
  logic [XLEN-1:0]    IdRsData;
  logic [XLEN-1:0]    IdRtData;
  logic [15:0]        IdImm;
  logic               MemRegWrite;
  logic [REGADDR-1:0] MemRd;
  logic [XLEN-1:0]    MemData;
  logic               WbRegWrite;
  logic [REGADDR-1:0] WbRd;
  logic [XLEN-1:0]    WbData;

  logic               HazardStall;
  logic               ExValid;
  logic [2:0]         Ctl;
  logic [4:0]         Shamt;
  logic [XLEN-1:0]    DataA;
  logic [XLEN-1:0]    DataB;
  logic [XLEN-1:0]    ExStoreData;
  logic               ExRegWrite;
  logic               ExMemRead;
  logic               ExMemWrite;
  logic               ExBranch;
  logic [REGADDR-1:0] ExWriteReg;

  modport master (
    output Stall, Flush, IdValid, IdOpcode, IdFunct, IdShamt, IdRs, IdRt, IdRd,
           IdRsData, IdRtData, IdImm, MemRegWrite, MemRd, MemData,
           WbRegWrite, WbRd, WbData,
    input  HazardStall, ExValid, Ctl, Shamt, DataA, DataB, ExStoreData,
           ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExWriteReg
  );

  modport slave (
    input  Stall, Flush, IdValid, IdOpcode, IdFunct, IdShamt, IdRs, IdRt, IdRd,
           IdRsData, IdRtData, IdImm, MemRegWrite, MemRd, MemData,
           WbRegWrite, WbRd, WbData,
    output HazardStall, ExValid, Ctl, Shamt, DataA, DataB, ExStoreData,
           ExRegWrite, ExMemRead, ExMemWrite, ExBranch, ExWriteReg
  );

endinterface

// File: rtl/id_ex_stage_alu_ctl_decode.sv
// alu_ctl_decode
// Purely combinational opcode/funct decoder for the ID/EX stage.
//   i_opcode : instr[31:26]
//   i_funct  : instr[5:0]
//   o_dec    : ALU control code plus RegWrite/MemRead/MemWrite/Branch/
//              UseImm/RegDst
// Anything not recognised decodes as ADD with every control bit clear,
// so it flows through the pipe as a harmless nop.
module alu_ctl_decode
  import pipe_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec        = '0;
    o_dec.ctl    = CTL_ADD;
    o_dec.regDst = (i_opcode == OP_RTYPE);
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.regWrite = 1'b1;
        case (i_funct)
          F_ADD:   o_dec.ctl = CTL_ADD;
          F_SUB:   o_dec.ctl = CTL_SUB;
          F_AND:   o_dec.ctl = CTL_AND;
          F_OR:    o_dec.ctl = CTL_OR;
          F_SLT:   o_dec.ctl = CTL_SLT;
          F_SRL:   o_dec.ctl = CTL_SRL;
          default: o_dec.regWrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_dec.regWrite = 1'b1;
        o_dec.useImm   = 1'b1;
      end
      OP_LW: begin
        o_dec.regWrite = 1'b1;
        o_dec.memRead  = 1'b1;
        o_dec.useImm   = 1'b1;
      end
      OP_SW: begin
        o_dec.memWrite = 1'b1;
        o_dec.useImm   = 1'b1;
      end
      OP_BEQ: begin
        o_dec.ctl    = CTL_SUB;
        o_dec.branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register sitting directly in front of the EX-stage ALU.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : id_ex_stage_if.slave -- ID fields, Stall/Flush, EX/MEM and MEM/WB
//          forwarding info in; HazardStall, forwarded ALU operands and
//          registered EX control out
// Update priority at each edge: Flush (bubble) > Stall (hold) >
// load-use hazard (bubble) > load the ID instruction.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic               r_valid;
  logic [2:0]         r_ctl;
  logic [4:0]         r_shamt;
  logic [REGADDR-1:0] r_rs;
  logic [REGADDR-1:0] r_rt;
  logic [XLEN-1:0]    r_rsData;
  logic [XLEN-1:0]    r_rtData;
  logic [XLEN-1:0]    r_imm;
  logic               r_regWrite;
  logic               r_memRead;
  logic               r_memWrite;
  logic               r_branch;
  logic               r_useImm;
  logic [REGADDR-1:0] r_writeReg;

  dec_t               w_dec;
  logic [REGADDR-1:0] w_writeReg;
  logic               w_hazard;
  fwd_e               w_fwdA;
  fwd_e               w_fwdB;
  logic [XLEN-1:0]    w_opA;
  logic [XLEN-1:0]    w_opB;

  alu_ctl_decode u_dec (
    .i_opcode (bus.IdOpcode),
    .i_funct  (bus.IdFunct),
    .o_dec    (w_dec)
  );

  assign w_writeReg = w_dec.regDst ? bus.IdRd : bus.IdRt;

  // A load in EX whose result is needed by the instruction in ID cannot be
  // forwarded in time; hold IF/ID for one cycle while a bubble goes in.
  assign w_hazard = !rst && r_valid && r_memRead && (r_writeReg != '0) &&
                    bus.IdValid &&
                    ((bus.IdRs == r_writeReg) || (bus.IdRt == r_writeReg));

  // Control bits are qualified with IdValid so an empty ID slot never
  // produces side effects; writes to $0 are dropped here once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctl      <= '0;
      r_shamt    <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rsData   <= '0;
      r_rtData   <= '0;
      r_imm      <= '0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_branch   <= 1'b0;
      r_useImm   <= 1'b0;
      r_writeReg <= '0;
    end else if (bus.Flush || (!bus.Stall && w_hazard)) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_branch   <= 1'b0;
    end else if (!bus.Stall) begin
      r_valid    <= bus.IdValid;
      r_ctl      <= w_dec.ctl;
      r_shamt    <= bus.IdShamt;
      r_rs       <= bus.IdRs;
      r_rt       <= bus.IdRt;
      r_rsData   <= bus.IdRsData;
      r_rtData   <= bus.IdRtData;
      r_imm      <= {{(XLEN-16){bus.IdImm[15]}}, bus.IdImm};
      r_regWrite <= bus.IdValid && w_dec.regWrite && (w_writeReg != '0);
      r_memRead  <= bus.IdValid && w_dec.memRead;
      r_memWrite <= bus.IdValid && w_dec.memWrite;
      r_branch   <= bus.IdValid && w_dec.branch;
      r_useImm   <= w_dec.useImm;
      r_writeReg <= w_writeReg;
    end
  end

  // Source selection: the younger EX/MEM result beats MEM/WB; $0 is never
  // forwarded, and a bubble in EX uses no forwarding at all.
  always_comb begin
    w_fwdA = FWD_NONE;
    w_fwdB = FWD_NONE;
    if (r_valid) begin
      if (bus.MemRegWrite && (bus.MemRd != '0) && (bus.MemRd == r_rs))
        w_fwdA = FWD_MEM;
      else if (bus.WbRegWrite && (bus.WbRd != '0) && (bus.WbRd == r_rs))
        w_fwdA = FWD_WB;
      if (bus.MemRegWrite && (bus.MemRd != '0) && (bus.MemRd == r_rt))
        w_fwdB = FWD_MEM;
      else if (bus.WbRegWrite && (bus.WbRd != '0) && (bus.WbRd == r_rt))
        w_fwdB = FWD_WB;
    end
  end

  always_comb begin
    case (w_fwdA)
      FWD_MEM: w_opA = bus.MemData;
      FWD_WB:  w_opA = bus.WbData;
      default: w_opA = r_rsData;
    endcase
    case (w_fwdB)
      FWD_MEM: w_opB = bus.MemData;
      FWD_WB:  w_opB = bus.WbData;
      default: w_opB = r_rtData;
    endcase
  end

  assign bus.HazardStall = w_hazard;
  assign bus.ExValid     = r_valid;
  assign bus.Ctl         = r_ctl;
  assign bus.Shamt       = r_shamt;
  assign bus.DataA       = w_opA;
  assign bus.DataB       = r_useImm ? r_imm : w_opB;
  assign bus.ExStoreData = w_opB;
  assign bus.ExRegWrite  = r_regWrite;
  assign bus.ExMemRead   = r_memRead;
  assign bus.ExMemWrite  = r_memWrite;
  assign bus.ExBranch    = r_branch;
  assign bus.ExWriteReg  = r_writeReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed checks of the ID/EX register followed by randomized traffic.
// Expected values come from a reference model of the instruction held in
// EX, built from the opcode/funct table, forwarding priority and the
// Flush > Stall > hazard > load update order.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REGADDR(5)) bus ();

  id_ex_stage #(.XLEN(32), .REGADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  ctl;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  writeReg;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        useImm;
  } exp_t;

  exp_t m;

  // compare one observed value against the expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drive the ID-stage instruction plus Stall/Flush
  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input logic [15:0] imm, input logic st, input logic fl);
    bus.IdValid = v;   bus.IdOpcode = op; bus.IdFunct = fn; bus.IdShamt = sh;
    bus.IdRs = rs;     bus.IdRt = rt;     bus.IdRd = rd;
    bus.IdRsData = a;  bus.IdRtData = b;  bus.IdImm = imm;
    bus.Stall = st;    bus.Flush = fl;
  endtask

  task automatic setFwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] md,
                        input logic wrw, input logic [4:0] wrd, input logic [31:0] wd);
    bus.MemRegWrite = mrw; bus.MemRd = mrd; bus.MemData = md;
    bus.WbRegWrite = wrw;  bus.WbRd = wrd;  bus.WbData = wd;
  endtask

  function automatic logic [31:0] fwdRef(input logic [4:0] r, input logic [31:0] d);
    if (bus.MemRegWrite && r != 0 && bus.MemRd == r) return bus.MemData;
    if (bus.WbRegWrite && r != 0 && bus.WbRd == r) return bus.WbData;
    return d;
  endfunction

  function automatic logic hazRef();
    return m.valid && m.memRead && m.writeReg != 0 && bus.IdValid &&
           (bus.IdRs == m.writeReg || bus.IdRt == m.writeReg);
  endfunction

  // what the EX slot should hold after loading the ID instruction
  function automatic exp_t decodeRef();
    exp_t e;
    e = '{default: '0};
    e.valid = bus.IdValid;
    e.ctl = 3'b010;
    e.shamt = bus.IdShamt;
    e.rs = bus.IdRs; e.rt = bus.IdRt;
    e.rsData = bus.IdRsData; e.rtData = bus.IdRtData;
    e.imm = 32'($signed(bus.IdImm));
    e.writeReg = (bus.IdOpcode == 6'd0) ? bus.IdRd : bus.IdRt;
    case (bus.IdOpcode)
      6'd0: begin
        e.regWrite = 1'b1;
        case (bus.IdFunct)
          6'h20: e.ctl = 3'b010;
          6'h22: e.ctl = 3'b110;
          6'h24: e.ctl = 3'b000;
          6'h25: e.ctl = 3'b001;
          6'h2a: e.ctl = 3'b011;
          6'h02: e.ctl = 3'b111;
          default: e.regWrite = 1'b0;
        endcase
      end
      6'h08: begin e.regWrite = 1'b1; e.useImm = 1'b1; end
      6'h23: begin e.regWrite = 1'b1; e.memRead = 1'b1; e.useImm = 1'b1; end
      6'h2b: begin e.memWrite = 1'b1; e.useImm = 1'b1; end
      6'h04: begin e.ctl = 3'b110; e.branch = 1'b1; end
      default: ;
    endcase
    if (!e.valid) begin
      e.regWrite = 1'b0; e.memRead = 1'b0; e.memWrite = 1'b0; e.branch = 1'b0;
    end
    if (e.writeReg == 0) e.regWrite = 1'b0;
    return e;
  endfunction

  function automatic void bubble();
    m.valid = 1'b0; m.regWrite = 1'b0; m.memRead = 1'b0;
    m.memWrite = 1'b0; m.branch = 1'b0;
  endfunction

  task automatic checkModel();
    checkOutput("HazardStall", 32'(bus.HazardStall), 32'(hazRef()));
    checkOutput("ExValid", 32'(bus.ExValid), 32'(m.valid));
    checkOutput("ExRegWrite", 32'(bus.ExRegWrite), 32'(m.regWrite));
    checkOutput("ExMemRead", 32'(bus.ExMemRead), 32'(m.memRead));
    checkOutput("ExMemWrite", 32'(bus.ExMemWrite), 32'(m.memWrite));
    checkOutput("ExBranch", 32'(bus.ExBranch), 32'(m.branch));
    if (m.valid) begin
      checkOutput("Ctl", 32'(bus.Ctl), 32'(m.ctl));
      checkOutput("Shamt", 32'(bus.Shamt), 32'(m.shamt));
      checkOutput("ExWriteReg", 32'(bus.ExWriteReg), 32'(m.writeReg));
      checkOutput("DataA", bus.DataA, fwdRef(m.rs, m.rsData));
      checkOutput("DataB", bus.DataB, m.useImm ? m.imm : fwdRef(m.rt, m.rtData));
      checkOutput("ExStoreData", bus.ExStoreData, fwdRef(m.rt, m.rtData));
    end
  endtask

  // check current outputs, advance the model, then cross one clock edge
  task automatic stepCycle();
    #1;
    checkModel();
    if (bus.Flush) bubble();
    else if (bus.Stall) ;
    else if (hazRef()) bubble();
    else m = decodeRef();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h02};
    m = '{default: '0};

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ExValid", 32'(bus.ExValid), 0);
    checkOutput("reset Ctl", 32'(bus.Ctl), 0);
    checkOutput("reset HazardStall", 32'(bus.HazardStall), 0);
    rst = 1'b0;

    // add $3, $1, $2
    applyStimulus(1, 6'h00, 6'h20, 0, 1, 2, 3, 5, 7, 0, 0, 0);
    stepCycle();
    checkOutput("add Ctl", 32'(bus.Ctl), 32'h2);
    checkOutput("add DataA", bus.DataA, 5);
    checkOutput("add DataB", bus.DataB, 7);
    checkOutput("add ExWriteReg", 32'(bus.ExWriteReg), 3);
    checkOutput("add ExRegWrite", 32'(bus.ExRegWrite), 1);

    // forwarding onto the held add
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    setFwd(1, 1, 32'hAA, 0, 0, 0);
    #1 checkOutput("fwd mem DataA", bus.DataA, 32'hAA);
    setFwd(1, 1, 32'hAA, 1, 1, 32'hBB);
    #1 checkOutput("fwd mem over wb", bus.DataA, 32'hAA);
    setFwd(0, 0, 0, 1, 1, 32'hBB);
    #1 checkOutput("fwd wb DataA", bus.DataA, 32'hBB);
    stepCycle();

    // $0 is never forwarded
    applyStimulus(1, 6'h00, 6'h20, 0, 0, 2, 3, 32'h1234, 7, 0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    stepCycle();
    setFwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    #1 checkOutput("zero guard DataA", bus.DataA, 32'h1234);
    setFwd(0, 0, 0, 0, 0, 0);

    // lw $4, 8($1) then add $6, $4, $2
    applyStimulus(1, 6'h23, 0, 0, 1, 4, 0, 32'h100, 0, 16'h8, 0, 0);
    stepCycle();
    applyStimulus(1, 6'h00, 6'h20, 0, 4, 2, 6, 32'h11, 32'h22, 0, 0, 0);
    #1 checkOutput("loaduse HazardStall", 32'(bus.HazardStall), 1);
    stepCycle();
    checkOutput("loaduse bubble", 32'(bus.ExValid), 0);
    checkOutput("loaduse hazard released", 32'(bus.HazardStall), 0);
    stepCycle();
    checkOutput("loaduse add loaded", 32'(bus.ExValid), 1);
    checkOutput("loaduse add dest", 32'(bus.ExWriteReg), 6);

    // addi $5, $1, -4 then srl $7, $2, 3
    applyStimulus(1, 6'h08, 0, 0, 1, 5, 0, 32'h9, 32'h9, 16'hFFFC, 0, 0);
    stepCycle();
    checkOutput("addi DataB", bus.DataB, 32'hFFFFFFFC);
    checkOutput("addi Ctl", 32'(bus.Ctl), 32'h2);
    checkOutput("addi ExWriteReg", 32'(bus.ExWriteReg), 5);
    applyStimulus(1, 6'h00, 6'h02, 3, 1, 2, 7, 1, 32'h80, 0, 0, 0);
    stepCycle();
    checkOutput("srl Ctl", 32'(bus.Ctl), 32'h7);
    checkOutput("srl Shamt", 32'(bus.Shamt), 3);

    // Flush wins over Stall
    applyStimulus(1, 6'h00, 6'h20, 0, 1, 2, 3, 5, 7, 0, 1, 1);
    stepCycle();
    checkOutput("flush+stall ExValid", 32'(bus.ExValid), 0);

    // Stall holds for three cycles
    applyStimulus(1, 6'h00, 6'h25, 0, 1, 2, 9, 32'h55, 32'h66, 0, 0, 0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6'h00, 6'h22, 0, 3, 4, 10, $urandom, $urandom, 0, 1, 0);
      stepCycle();
    end
    checkOutput("stall hold DataA", bus.DataA, 32'h55);
    checkOutput("stall hold Ctl", 32'(bus.Ctl), 32'h1);

    // asynchronous reset mid-stream
    applyStimulus(1, 6'h00, 6'h20, 0, 1, 2, 3, 5, 7, 0, 0, 0);
    stepCycle();
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset ExValid", 32'(bus.ExValid), 0);
    checkOutput("async reset HazardStall", 32'(bus.HazardStall), 0);
    m = '{default: '0};
    @(posedge clk);
    #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)],
                    ($urandom_range(0, 6) == 6) ? 6'($urandom) : fns[$urandom_range(0, 5)],
                    5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      setFwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
